pc_fetch_unit: RTL and testbench

- Program-counter and fetch-address generator directly upstream of the combinational instruction memory.
- Drives the memory's 32-bit byte read address each cycle and selects the next PC from sequential, branch or jump sources.
- Adds stall hold, misalignment and range checking with a sticky halt, and a fetch counter for bring-up benches.

---
 rtl/pc_fetch_unit.sv | 124 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-address generator feeding a combinational instruction memory.
// Optional build macro PC_WRAP_EN: sequential fetch past the end of memory wraps to 0 instead of faulting.
module pc_fetch_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned      IMEM_BYTES = 1024,
  parameter int unsigned      CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branchTaken,
  input  logic [WIDTH-1:0] branchTarget,
  input  logic             jumpEn,
  input  logic [WIDTH-1:0] jumpTarget,
  output logic [WIDTH-1:0] readAddr,
  output logic [WIDTH-1:0] pcPlus4,
  output logic             fetchValid,
  output logic             halted,
  output logic [1:0]       faultCause,
  output logic [CNT_W-1:0] fetchCount
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;

  // One extra bit so the limit stays representable even when it equals 2^WIDTH.
  localparam logic [WIDTH:0] IMEM_LIMIT = (WIDTH+1)'(IMEM_BYTES);

`ifdef PC_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] pc;
  logic [1:0]       cause;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] next_pc;
  logic             seq_sel;
  logic             misaligned;
  logic             out_of_range;
  logic [1:0]       fault;

  assign pcPlus4 = pc + WIDTH'(4);

  // Candidate selection and fault classification; stall is applied in the register stage.
  always_comb begin
    seq_sel = 1'b0;
    if (jumpEn) begin
      cand = jumpTarget;
    end else if (branchTaken) begin
      cand = branchTarget;
    end else begin
      cand    = pcPlus4;
      seq_sel = 1'b1;
    end

    misaligned   = (cand[1:0] != 2'b00);
    out_of_range = ({1'b0, cand} >= IMEM_LIMIT);

    next_pc = cand;
    fault   = FC_NONE;
    if (misaligned) begin
      fault = FC_MISALIGN;
    end else if (out_of_range) begin
      if (WRAP_EN && seq_sel) begin
        next_pc = '0;
      end else begin
        fault = FC_RANGE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
      cause <= FC_NONE;
      count <= '0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (!stall) begin
            if (fault != FC_NONE) begin
              state <= ST_HALT;
              cause <= fault;
            end else begin
              pc <= next_pc;
              if (count != '1) begin
                count <= count + CNT_W'(1);
              end
            end
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_HALT;
      endcase
    end
  end

  assign readAddr   = pc;
  assign fetchValid = (state == ST_RUN);
  assign halted     = (state == ST_HALT);
  assign faultCause = cause;
  assign fetchCount = count;

  // A live fetch address is always word-aligned and inside the memory.
  a_live_addr_ok: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_RUN) |-> (pc[1:0] == 2'b00 && {1'b0, pc} < IMEM_LIMIT));

  a_halt_sticky: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_HALT) |=> (state == ST_HALT && $stable(pc) && $stable(cause)));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios plus random stimulus against a behavioural model.
module tb_pc_fetch_unit;

  localparam int unsigned IMEM  = 128;
  localparam int unsigned CNTW  = 4;
  localparam longint unsigned CNT_MAX = (64'd1 << CNTW) - 1;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jumpEn;
  logic [31:0] jumpTarget;
  logic [31:0] readAddr;
  logic [31:0] pcPlus4;
  logic        fetchValid;
  logic        halted;
  logic [1:0]  faultCause;
  logic [CNTW-1:0] fetchCount;

  pc_fetch_unit #(
    .WIDTH(32),
    .RESET_PC(32'd0),
    .IMEM_BYTES(IMEM),
    .CNT_W(CNTW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .branchTaken(branchTaken),
    .branchTarget(branchTarget),
    .jumpEn(jumpEn),
    .jumpTarget(jumpTarget),
    .readAddr(readAddr),
    .pcPlus4(pcPlus4),
    .fetchValid(fetchValid),
    .halted(halted),
    .faultCause(faultCause),
    .fetchCount(fetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ra;
    logic [31:0] p4;
    logic        fv;
    logic        h;
    logic [1:0]  fc;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model state
  longint unsigned m_pc;
  longint unsigned m_cnt;
  bit              m_boot;
  bit              m_halt;
  int unsigned     m_cause;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit rst, input bit st, input bit br, input logic [31:0] bt,
                       input bit jp, input logic [31:0] jt);
    longint unsigned tgt;
    bit seq;
    if (!rst) begin
      m_pc = 0; m_cnt = 0; m_boot = 1; m_halt = 0; m_cause = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!m_halt && !st) begin
      seq = 0;
      if (jp)      tgt = jt;
      else if (br) tgt = bt;
      else begin   tgt = (m_pc + 4) % 64'h1_0000_0000; seq = 1; end
      if (tgt % 4 != 0) begin
        m_halt = 1; m_cause = 1;
      end else if (tgt >= IMEM) begin
`ifdef PC_WRAP_EN
        if (seq) begin
          m_pc = 0;
          if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
          m_halt = 1; m_cause = 2;
        end
`else
        m_halt = 1; m_cause = 2;
`endif
      end else begin
        m_pc = tgt;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
  endtask

  // Drive at a falling edge, record expectation for the next rising edge, advance to next falling edge.
  task automatic step(input bit rst, input bit st, input bit br, input logic [31:0] bt,
                      input bit jp, input logic [31:0] jt);
    exp_t e;
    rst_n = rst; stall = st; branchTaken = br; branchTarget = bt; jumpEn = jp; jumpTarget = jt;
    model(rst, st, br, bt, jp, jt);
    e.ra  = 32'(m_pc);
    e.p4  = 32'((m_pc + 4) % 64'h1_0000_0000);
    e.fv  = !m_boot && !m_halt;
    e.h   = m_halt;
    e.fc  = 2'(m_cause);
    e.cnt = 32'(m_cnt);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_target();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0)      return $urandom;
    else if (r == 1) return 32'($urandom_range(0, 40) * 4 + $urandom_range(1, 3));
    else             return 32'($urandom_range(0, 40) * 4);
  endfunction

  // Monitor: compare DUT outputs just after each rising edge against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("readAddr",   readAddr,         e.ra);
        check("pcPlus4",    pcPlus4,          e.p4);
        check("fetchValid", 32'(fetchValid),  32'(e.fv));
        check("halted",     32'(halted),      32'(e.h));
        check("faultCause", 32'(faultCause),  32'(e.fc));
        check("fetchCount", 32'(fetchCount),  e.cnt);
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0;
    jumpEn = 1'b0; jumpTarget = '0;
    @(negedge clk);

    // Free run from reset
    do_reset();
    check("boot_addr", readAddr, 32'd0);
    check("boot_fv", 32'(fetchValid), 32'd0);
    run(1);
    check("run_fv", 32'(fetchValid), 32'd1);
    run(7);
    check("freerun_addr", readAddr, 32'd28);
    check("freerun_cnt", 32'(fetchCount), 32'd7);

    // Stall with a dropped branch
    do_reset(); run(1); run(2);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 32'd40, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    check("stall_addr", readAddr, 32'd8);
    check("stall_cnt", 32'(fetchCount), 32'd2);
    run(1);
    check("post_stall_addr", readAddr, 32'd12);

    // Jump beats branch
    do_reset(); run(1); run(4);
    step(1, 0, 1, 32'd200, 1, 32'd100);
    check("jump_addr", readAddr, 32'd100);
    run(1);
    check("jump_seq_addr", readAddr, 32'd104);

    // Misaligned branch halts until reset
    do_reset(); run(1); run(3);
    step(1, 0, 1, 32'h22, 0, 0);
    check("mis_halted", 32'(halted), 32'd1);
    check("mis_cause", 32'(faultCause), 32'd1);
    check("mis_addr", readAddr, 32'd12);
    check("mis_fv", 32'(fetchValid), 32'd0);
    for (int i = 0; i < 10; i++)
      step(1, 1'($urandom), 1'($urandom), rand_target(), 1'($urandom), rand_target());
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_addr", readAddr, 32'd12);
    do_reset();
    check("clr_addr", readAddr, 32'd0);
    check("clr_halted", 32'(halted), 32'd0);

    // Sequential overflow at end of memory; counter saturation
    do_reset(); run(1); run(31);
    check("end_addr", readAddr, 32'd124);
    check("sat_cnt", 32'(fetchCount), 32'd15);
    run(1);
`ifdef PC_WRAP_EN
    check("wrap_addr", readAddr, 32'd0);
    check("wrap_halted", 32'(halted), 32'd0);
`else
    check("ovf_halted", 32'(halted), 32'd1);
    check("ovf_cause", 32'(faultCause), 32'd2);
    check("ovf_addr", readAddr, 32'd124);
`endif
    do_reset(); run(1);
    step(1, 0, 0, 0, 1, 32'd256);
    check("jump_range_cause", 32'(faultCause), 32'd2);
    check("jump_range_addr", readAddr, 32'd0);

    // Reset during a jump
    do_reset(); run(1); run(3);
    step(0, 0, 0, 0, 1, 32'd64);
    check("rst_jump_addr", readAddr, 32'd0);
    check("rst_jump_fv", 32'(fetchValid), 32'd0);
    run(1);
    check("rst_jump_run", 32'(fetchValid), 32'd1);

    // Random phase
    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 24) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, rand_target(),
           $urandom_range(0, 5) == 0, rand_target());

    repeat (2) @(negedge clk);
    check("queue_drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
